// File: rtl/crc_control_ab_if.sv
// Rx/Tx snoop bus and CRC results shared between the framing layer and crc_control_ab.
// rx_crc_err_count is present only when CRC_CONTROL_AB_ERR_COUNT_EN is defined.
interface crc_control_ab_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  crc_b_mode;
    logic                  rx_soc;
    logic                  rx_eoc;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_valid;
    logic                  tx_append_crc;
    logic                  fdt_trigger;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_valid;
    logic                  tx_req;
    logic [15:0]           crc;
    logic                  rx_crc_ok;
`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
    logic [7:0]            rx_crc_err_count;
`endif

    modport master (
        output crc_b_mode, rx_soc, rx_eoc, rx_data, rx_data_valid,
               tx_append_crc, fdt_trigger, tx_data, tx_data_valid, tx_req,
        input  crc, rx_crc_ok
`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
             , rx_crc_err_count
`endif
    );

    modport slave (
        input  crc_b_mode, rx_soc, rx_eoc, rx_data, rx_data_valid,
               tx_append_crc, fdt_trigger, tx_data, tx_data_valid, tx_req,
        output crc, rx_crc_ok
`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
             , rx_crc_err_count
`endif
    );
endinterface

// File: rtl/crc_control_ab.sv
// ISO/IEC 14443 CRC_A / CRC_B controller snooping Rx and Tx beats of 1 or 8 bits.
// Define CRC_CONTROL_AB_ERR_COUNT_EN to add the saturating Rx CRC error counter.
module crc_control_ab #(
    parameter int DATA_WIDTH = 1
) (
    input logic              clk,
    input logic              rst_n,
    crc_control_ab_if.slave  bus
);
    localparam logic [15:0] POLY      = 16'h8408;
    localparam logic [15:0] INIT_A    = 16'h6363;
    localparam logic [15:0] INIT_B    = 16'hFFFF;
    localparam logic [15:0] RESIDUE_B = 16'hF0B8;

    generate
        if (DATA_WIDTH != 1 && DATA_WIDTH != 8) begin : g_bad_width
            $error("crc_control_ab: DATA_WIDTH must be 1 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_RX_DONE, ST_TX, ST_TX_DONE} state_t;

    state_t      state, state_next;
    logic [15:0] crc_reg, crc_next;
    logic        mode_b, mode_next;
    logic        tx_start;

    // Reflected CRC-16: bit 0 of the beat enters first.
    function automatic logic [15:0] fold(input logic [15:0] c_in, input logic [DATA_WIDTH-1:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < DATA_WIDTH; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? POLY : 16'h0000);
        return c;
    endfunction

    function automatic logic residue_ok(input logic [15:0] c, input logic b);
        return b ? (c == RESIDUE_B) : (c == 16'h0000);
    endfunction

    assign tx_start = bus.fdt_trigger && bus.tx_append_crc && bus.tx_data_valid && (state != ST_TX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            crc_reg <= INIT_A;
            mode_b  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_next;
            crc_reg <= crc_next;
            mode_b  <= mode_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next = state;
        crc_next   = crc_reg;
        mode_next  = mode_b;
        if (tx_start) begin
            mode_next  = bus.crc_b_mode;
            state_next = ST_TX;
            crc_next   = bus.crc_b_mode ? INIT_B : INIT_A;
            if (bus.tx_req)
                crc_next = fold(crc_next, bus.tx_data);
        end else if (bus.rx_soc && state != ST_TX) begin
            mode_next  = bus.crc_b_mode;
            state_next = ST_RX;
            crc_next   = bus.crc_b_mode ? INIT_B : INIT_A;
            if (bus.rx_data_valid)
                crc_next = fold(crc_next, bus.rx_data);
        end else begin
            unique case (state)
                ST_RX: begin
                    if (bus.rx_data_valid)
                        crc_next = fold(crc_reg, bus.rx_data);
                    if (bus.rx_eoc)
                        state_next = ST_RX_DONE;
                end
                ST_TX: begin
                    if (bus.tx_req && bus.tx_data_valid)
                        crc_next = fold(crc_reg, bus.tx_data);
                    if (!bus.tx_data_valid)
                        state_next = ST_TX_DONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.crc       = mode_b ? ~crc_reg : crc_reg;
    assign bus.rx_crc_ok = (state != ST_TX) && (state != ST_TX_DONE) && residue_ok(crc_reg, mode_b);

`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
    logic [7:0] err_count;
    logic       rx_fail;

    // The residue is judged on crc_next so a beat arriving with rx_eoc is included.
    assign rx_fail = (state == ST_RX) && !tx_start && !bus.rx_soc && bus.rx_eoc &&
                     !residue_ok(crc_next, mode_b);

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= 8'h00;
        else if (rx_fail && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end

    assign bus.rx_crc_err_count = err_count;
`endif
endmodule

// File: tb/tb_crc_control_ab.sv
// Self-checking bench for crc_control_ab: byte (DATA_WIDTH=8) and bit (DATA_WIDTH=1) instances.
// Honours CRC_CONTROL_AB_ERR_COUNT_EN when the design is built with the error counter.
module tb_crc_control_ab;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_control_ab_if #(.DATA_WIDTH(8)) b8();
    crc_control_ab_if #(.DATA_WIDTH(1)) b1();

    crc_control_ab #(.DATA_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    crc_control_ab #(.DATA_WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int err_exp = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: bitwise long division of the reflected polynomial, LSB of each byte first.
    function automatic logic [15:0] crc_raw(input byte_q_t q, input bit b);
        logic [15:0] c;
        c = b ? 16'hFFFF : 16'h6363;
        foreach (q[i])
            for (int k = 0; k < 8; k++) begin
                if (c[0] != q[i][k]) c = (c >> 1) ^ 16'h8408;
                else                 c = c >> 1;
            end
        return c;
    endfunction

    function automatic logic [15:0] crc_out(input byte_q_t q, input bit b);
        return b ? ~crc_raw(q, b) : crc_raw(q, b);
    endfunction

    function automatic byte_q_t with_crc(input byte_q_t q, input bit b);
        byte_q_t r;
        logic [15:0] v;
        r = q;
        v = crc_out(q, b);
        r.push_back(v[7:0]);
        r.push_back(v[15:8]);
        return r;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom));
        return r;
    endfunction

    task automatic idle_all();
        b8.crc_b_mode = 0; b8.rx_soc = 0; b8.rx_eoc = 0; b8.rx_data = '0; b8.rx_data_valid = 0;
        b8.tx_append_crc = 0; b8.fdt_trigger = 0; b8.tx_data = '0; b8.tx_data_valid = 0; b8.tx_req = 0;
        b1.crc_b_mode = 0; b1.rx_soc = 0; b1.rx_eoc = 0; b1.rx_data = '0; b1.rx_data_valid = 0;
        b1.tx_append_crc = 0; b1.fdt_trigger = 0; b1.tx_data = '0; b1.tx_data_valid = 0; b1.tx_req = 0;
    endtask

    // Byte Tx frame with random stalls, spurious rx_soc/fdt_trigger and a mode toggle after start.
    task automatic tx8(input byte_q_t q, input bit b, input bit soc, input string tag, input logic [15:0] exp);
        b8.crc_b_mode = b; b8.fdt_trigger = 1; b8.tx_append_crc = 1;
        b8.tx_data_valid = 1; b8.tx_req = 1; b8.tx_data = q[0]; b8.rx_soc = soc;
        tick();
        b8.crc_b_mode = ~b;
        for (int i = 1; i < q.size(); i++) begin
            b8.tx_data = q[i]; b8.tx_req = 0;
            b8.rx_soc = 1'($urandom_range(0, 1)); b8.fdt_trigger = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            b8.tx_req = 1;
            tick();
        end
        b8.tx_data_valid = 0; b8.tx_req = 0; b8.tx_append_crc = 0; b8.rx_soc = 0; b8.fdt_trigger = 0;
        tick();
        b8.crc_b_mode = 0;
        check({tag, "_crc"}, b8.crc, exp);
        check({tag, "_ok_forced0"}, {15'd0, b8.rx_crc_ok}, 16'd0);
    endtask

    task automatic tx1(input byte_q_t q, input bit b, input string tag, input logic [15:0] exp);
        int nb;
        nb = 8 * q.size();
        b1.crc_b_mode = b; b1.fdt_trigger = 1; b1.tx_append_crc = 1;
        b1.tx_data_valid = 1; b1.tx_req = 1; b1.tx_data = q[0][0];
        tick();
        b1.fdt_trigger = 0; b1.crc_b_mode = ~b;
        for (int i = 1; i < nb; i++) begin
            b1.tx_data = q[i / 8][i % 8];
            tick();
        end
        b1.tx_data_valid = 0; b1.tx_req = 0; b1.tx_append_crc = 0;
        tick();
        b1.crc_b_mode = 0;
        check({tag, "_crc_w1"}, b1.crc, exp);
    endtask

    // Byte Rx frame: first beat coincides with rx_soc, last beat with rx_eoc, random gaps between.
    task automatic rx8(input byte_q_t q, input bit b, input bit exp_ok, input string tag);
        b8.rx_soc = 1; b8.crc_b_mode = b; b8.rx_data_valid = 1; b8.rx_data = q[0];
        tick();
        b8.rx_soc = 0; b8.crc_b_mode = ~b;
        for (int i = 1; i < q.size(); i++) begin
            b8.rx_data_valid = 0; b8.rx_data = 8'($urandom);
            repeat ($urandom_range(0, 1)) tick();
            b8.rx_data_valid = 1; b8.rx_data = q[i]; b8.rx_eoc = (i == q.size() - 1);
            tick();
        end
        b8.rx_data_valid = 0; b8.rx_eoc = 0; b8.crc_b_mode = 0;
        check({tag, "_ok"}, {15'd0, b8.rx_crc_ok}, {15'd0, exp_ok});
        check({tag, "_crc"}, b8.crc, crc_out(q, b));
        if (!exp_ok && err_exp < 255) err_exp++;
`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
        check({tag, "_errcnt"}, {8'd0, b8.rx_crc_err_count}, 16'(err_exp));
`endif
    endtask

    initial begin
        byte_q_t q;
        bit b;
        int idx;

        idle_all();
        rst_n = 0;
        repeat (3) tick();
        check("rst_crc8", b8.crc, 16'h6363);
        check("rst_ok8", {15'd0, b8.rx_crc_ok}, 16'd0);
        check("rst_crc1", b1.crc, 16'h6363);
        check("rst_ok1", {15'd0, b1.rx_crc_ok}, 16'd0);
        rst_n = 1;
        tick();

        // Known Tx vectors on both widths
        tx8('{8'h00, 8'h00}, 0, 0, "txA_0000", 16'h1EA0);
        tx1('{8'h00, 8'h00}, 0, "txA_0000", 16'h1EA0);
        tx8('{8'h12, 8'h34}, 0, 0, "txA_1234", 16'hCF26);
        tx1('{8'h12, 8'h34}, 0, "txA_1234", 16'hCF26);
        tx8('{8'h00, 8'h00, 8'h00}, 1, 0, "txB_000000", 16'hC6CC);
        tx1('{8'h00, 8'h00, 8'h00}, 1, "txB_000000", 16'hC6CC);
        tx8('{8'h0F, 8'hAA, 8'hFF}, 1, 0, "txB_0FAAFF", 16'hD1FC);
        tx1('{8'h0F, 8'hAA, 8'hFF}, 1, "txB_0FAAFF", 16'hD1FC);

        // Start gating: crc must hold D1FC (mode B latched) throughout
        b8.fdt_trigger = 1; b8.tx_append_crc = 0; b8.tx_data_valid = 1; b8.tx_req = 1;
        repeat ($urandom_range(1, 10)) begin
            b8.tx_data = 8'($urandom); b8.crc_b_mode = 1'($urandom_range(0, 1));
            b8.rx_data_valid = 1'($urandom_range(0, 1)); b8.rx_data = 8'($urandom);
            tick();
            check("gate_no_append", b8.crc, 16'hD1FC);
        end
        b8.tx_append_crc = 1; b8.tx_data_valid = 0;
        tick();
        b8.fdt_trigger = 0; b8.tx_data_valid = 1;
        repeat ($urandom_range(1, 10)) begin
            b8.tx_data = 8'($urandom); b8.crc_b_mode = 1'($urandom_range(0, 1));
            tick();
            check("gate_no_valid", b8.crc, 16'hD1FC);
        end
        repeat ($urandom_range(1, 10)) begin
            b8.tx_data = 8'($urandom); b8.crc_b_mode = 1'($urandom_range(0, 1));
            tick();
            check("gate_no_fdt", b8.crc, 16'hD1FC);
        end
        idle_all();
        tick();

        // Tx of a frame carrying its own CRC_A: raw residue 0, but rx_crc_ok stays forced low
        q = with_crc(rand_bytes(4), 0);
        tx8(q, 0, 0, "tx_selfcrc", 16'h0000);

        // Known Rx vectors
        rx8('{8'h00, 8'h00, 8'hA0, 8'h1E}, 0, 1, "rxA_known");
        rx8('{8'h00, 8'h00, 8'h00, 8'hCC, 8'hC6}, 1, 1, "rxB_known");

        // rx_soc coincident with a Tx start: Tx wins
        q = rand_bytes(3);
        tx8(q, 1, 1, "soc_vs_tx", crc_out(q, 1));

        // Reset in the middle of an Rx frame
        b8.rx_soc = 1; b8.crc_b_mode = 1; b8.rx_data_valid = 1; b8.rx_data = 8'h5A;
        tick();
        b8.rx_soc = 0; b8.rx_data = 8'hC3;
        tick();
        rst_n = 0;
        tick();
        check("rst_midrx_crc", b8.crc, 16'h6363);
        check("rst_midrx_ok", {15'd0, b8.rx_crc_ok}, 16'd0);
        err_exp = 0;
        idle_all();
        rst_n = 1;
        tick();

        // Random Tx frames
        for (int n = 0; n < 100; n++) begin
            b = 1'($urandom_range(0, 1));
            q = rand_bytes($urandom_range(1, 8));
            tx8(q, b, 0, "tx_rand", crc_out(q, b));
        end

        // Random Rx frames with correct CRC appended
        for (int n = 0; n < 1000; n++) begin
            b = 1'($urandom_range(0, 1));
            q = with_crc(rand_bytes($urandom_range(1, 8)), b);
            rx8(q, b, 1, "rx_good");
        end

        // Random Rx frames with one flipped bit
        for (int n = 0; n < 1000; n++) begin
            b = 1'($urandom_range(0, 1));
            q = with_crc(rand_bytes($urandom_range(1, 8)), b);
            idx = $urandom_range(0, 8 * q.size() - 1);
            q[idx / 8][idx % 8] = ~q[idx / 8][idx % 8];
            rx8(q, b, 0, "rx_bad");
        end
`ifdef CRC_CONTROL_AB_ERR_COUNT_EN
        check("errcnt_saturated", {8'd0, b8.rx_crc_err_count}, 16'h00FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
